rob_dispatch: RTL



---
 rtl/rob_dispatch_if.sv | 31 +++
 rtl/rob_dispatch.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rob_dispatch_if.sv
// Rename-to-dispatch and dispatch-to-ROB signal bundle.
// The slave modport is the dispatch stage, the master modport is its environment.
interface rob_dispatch_if #(
  parameter int IDX_W     = 7,
  parameter int NUM_LANES = 4
);
  logic [NUM_LANES-1:0]             decValid;
  logic [NUM_LANES-1:0][4:0]        decArchReg;
  logic [NUM_LANES-1:0][7:0]        decPhysReg;
  logic [NUM_LANES-1:0][10:0]       decOpcode;
  logic                             decReady;
  logic [NUM_LANES-1:0][IDX_W-1:0]  decRobIndex;
  logic [NUM_LANES-1:0]             inserted;
  logic [NUM_LANES-1:0][4:0]        archReg;
  logic [NUM_LANES-1:0][7:0]        physReg;
  logic [NUM_LANES-1:0][10:0]       opcode;
  logic [2:0]                       numCommited;
  logic                             robFull;
  logic                             flushAll;
  logic [IDX_W:0]                   occupancy;
  logic                             occErr;

  modport master (
    output decValid, decArchReg, decPhysReg, decOpcode, numCommited, robFull, flushAll,
    input  decReady, decRobIndex, inserted, archReg, physReg, opcode, occupancy, occErr
  );
  modport slave (
    input  decValid, decArchReg, decPhysReg, decOpcode, numCommited, robFull, flushAll,
    output decReady, decRobIndex, inserted, archReg, physReg, opcode, occupancy, occErr
  );
endinterface

// File: rtl/rob_dispatch.sv
// 4-wide dispatch: compacts a sparse rename bundle into a one-entry stage and
// inserts it into the ROB, tracking a local mirror of ROB tail and occupancy.
module rob_dispatch_lane #(
  parameter int LANE      = 0,
  parameter int NUM_LANES = 4,
  parameter int IDX_W     = 7
) (
  input  logic [NUM_LANES-1:0]        valid,
  input  logic [NUM_LANES-1:0][4:0]   arch_in,
  input  logic [NUM_LANES-1:0][7:0]   phys_in,
  input  logic [NUM_LANES-1:0][10:0]  opc_in,
  input  logic [IDX_W-1:0]            tail,
  output logic [4:0]                  arch,
  output logic [7:0]                  phys,
  output logic [10:0]                 opc,
  output logic [IDX_W-1:0]            rob_idx
);
  logic [2:0] rank;

  // Output lane LANE takes the LANE-th set bit of the valid mask.
  always_comb begin
    arch = '0;
    phys = '0;
    opc  = '0;
    rank = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      if (valid[j]) begin
        if (rank == 3'(LANE)) begin
          arch = arch_in[j];
          phys = phys_in[j];
          opc  = opc_in[j];
        end
        rank = rank + 3'd1;
      end
    end
  end

  assign rob_idx = tail + IDX_W'(LANE);
endmodule

module rob_dispatch #(
  parameter int ROB_DEPTH = 128,
  parameter int IDX_W     = 7
) (
  input  logic          clk,
  input  logic          reset,
  rob_dispatch_if.slave bus
);
  localparam int NL = 4;
  localparam logic [NL:0] ONE = (NL+1)'(1);

  logic                   stage_valid;
  logic [2:0]             stage_cnt;
  logic [NL-1:0][4:0]     stage_arch;
  logic [NL-1:0][7:0]     stage_phys;
  logic [NL-1:0][10:0]    stage_opc;
  logic [IDX_W-1:0]       tail;
  logic [IDX_W:0]         occ;
  logic                   occ_err;

  logic [NL-1:0][4:0]     cmp_arch;
  logic [NL-1:0][7:0]     cmp_phys;
  logic [NL-1:0][10:0]    cmp_opc;
  logic [2:0]             in_cnt;
  logic [IDX_W+1:0]       occ_sum;
  logic [IDX_W+1:0]       occ_calc;
  logic [2:0]             fire_cnt;
  logic [NL:0]            therm;
  logic                   stall, fire, ready, capture, underflow, overflow;

  for (genvar k = 0; k < NL; k++) begin : g_lane
    rob_dispatch_lane #(.LANE(k), .NUM_LANES(NL), .IDX_W(IDX_W)) u_lane (
      .valid   (bus.decValid),
      .arch_in (bus.decArchReg),
      .phys_in (bus.decPhysReg),
      .opc_in  (bus.decOpcode),
      .tail    (tail),
      .arch    (cmp_arch[k]),
      .phys    (cmp_phys[k]),
      .opc     (cmp_opc[k]),
      .rob_idx (bus.decRobIndex[k])
    );
  end

  always_comb begin
    in_cnt = '0;
    for (int j = 0; j < NL; j++) in_cnt = in_cnt + {2'b00, bus.decValid[j]};
  end

  // Stall looks only at the registered occupancy so numCommited has no path to fire.
  assign occ_sum  = {1'b0, occ} + {{(IDX_W-1){1'b0}}, stage_cnt};
  assign stall    = bus.robFull | (occ_sum > (IDX_W+2)'(ROB_DEPTH));
  assign fire     = stage_valid & ~stall & ~bus.flushAll;
  assign ready    = (~stage_valid | fire) & ~bus.flushAll;
  assign capture  = ready & (|bus.decValid);
  assign fire_cnt = fire ? stage_cnt : 3'd0;

  // Top bit of the widened result is the sign: commits exceeded what we hold.
  assign occ_calc  = {1'b0, occ} + {{(IDX_W-1){1'b0}}, fire_cnt}
                   - {{(IDX_W-1){1'b0}}, bus.numCommited};
  assign underflow = occ_calc[IDX_W+1];
  assign overflow  = ~underflow & (occ_calc > (IDX_W+2)'(ROB_DEPTH));

  assign therm        = (ONE << stage_cnt) - ONE;
  assign bus.inserted = fire ? therm[NL-1:0] : '0;
  assign bus.decReady = ready;
  assign bus.archReg  = stage_arch;
  assign bus.physReg  = stage_phys;
  assign bus.opcode   = stage_opc;
  assign bus.occupancy = occ;
  assign bus.occErr   = occ_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid <= 1'b0;
      stage_cnt   <= '0;
      stage_arch  <= '0;
      stage_phys  <= '0;
      stage_opc   <= '0;
    end else if (bus.flushAll) begin
      stage_valid <= 1'b0;
    end else if (capture) begin
      stage_valid <= 1'b1;
      stage_cnt   <= in_cnt;
      stage_arch  <= cmp_arch;
      stage_phys  <= cmp_phys;
      stage_opc   <= cmp_opc;
    end else if (fire) begin
      stage_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tail    <= '0;
      occ     <= '0;
      occ_err <= 1'b0;
    end else begin
      if (fire) tail <= tail + IDX_W'(stage_cnt);
      if (underflow)     occ <= '0;
      else if (overflow) occ <= (IDX_W+1)'(ROB_DEPTH);
      else               occ <= occ_calc[IDX_W:0];
      if (underflow | overflow) occ_err <= 1'b1;
    end
  end
endmodule
